// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter state encoding, parity helper.
// Pure declarations; no latency or flow control of its own.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_t;

    // Parity bit the wire should carry, given the XOR of the data bits.
    function automatic logic expected_parity(input logic data_xor, input int mode);
        return (mode == PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side word bus: one-cycle valid carrying data and error flags; 0 cycles latency.
// No backpressure: the slave must take the word on the valid cycle.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (output data, valid, parity_err, frame_err, busy);
    modport slave  (input  data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, reset value selectable.
// Latency 2 clk; no flow control.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver; valid pulses 1 clk after the final stop-bit mid-sample.
// No backpressure: the consumer must take data on the valid cycle.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    uart_rx_param_if.master   rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    logic                 din_s;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_bad;
    logic                 frm_bad;
    logic                 cnt_half;
    logic                 cnt_last;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    assign cnt_half = (cnt == HALF);
    assign cnt_last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            stop_idx      <= 1'b0;
            data_sr       <= '0;
            par_bad       <= 1'b0;
            frm_bad       <= 1'b0;
            rx.data       <= '0;
            rx.valid      <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.valid <= 1'b0;
            rx.busy  <= (state != ST_IDLE);
            cnt      <= cnt_last ? '0 : cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                    par_bad  <= 1'b0;
                    frm_bad  <= 1'b0;
                    if (!din_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt_half && din_s) state <= ST_IDLE;
                    else if (cnt_last)     state <= ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_half) data_sr[idx] <= din_s;
                    if (cnt_last) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt_half) par_bad <= (din_s != expected_parity(^data_sr, PARITY));
                    if (cnt_last) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (cnt_half) begin
                        if (stop_idx == LAST_STOP) begin
                            // Leave half a bit early so the next start edge is never missed.
                            rx.data       <= data_sr;
                            rx.valid      <= 1'b1;
                            rx.parity_err <= par_bad;
                            rx.frame_err  <= frm_bad | ~din_s;
                            state         <= (frm_bad | ~din_s) ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            frm_bad <= frm_bad | ~din_s;
                        end
                    end else if (cnt_last) begin
                        stop_idx <= 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    cnt <= '0;
                    if (din_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
